// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding/hazard unit.
package fwd_pkg;

  localparam int unsigned FWD_SEL_RF = 0;

  // Widest register address a tag can hold; narrower REG_AW values are zero-extended.
  localparam int unsigned TAG_AW_MAX = 8;

  typedef struct packed {
    logic                  valid;
    logic [TAG_AW_MAX-1:0] dst;
    logic                  regwrite;
    logic                  memtoreg;
  } tag_t;

  function automatic int unsigned sel_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_tag_pipe.sv
// Destination-tag shadow pipeline: entry 0 is EX, entry k is k stages older.
module fwd_tag_pipe
  import fwd_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  tag_t             tag_i,
  output tag_t [DEPTH-1:0] tags_o
);

  tag_t [DEPTH-1:0] tags_q, tags_d;

  always_comb begin
    tags_d    = tags_q;
    tags_d[0] = load_i ? tag_i : '0;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      tags_d[k] = tags_q[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) tags_q <= '0;
    else       tags_q <= tags_d;
  end

  assign tags_o = tags_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects, load-use stall and saturating stall counter.
// Optional FWD_ZERO_REG_EN: register 0 is hard-wired zero and never forwards or stalls.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter  int unsigned REG_AW    = 3,
  parameter  int unsigned NUM_SRC   = 2,
  parameter  int unsigned FWD_DEPTH = 2,
  parameter  int unsigned CNT_W     = 16,
  localparam int unsigned SELW      = sel_width(FWD_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_AW-1:0]         id_dst,
  input  logic                      id_regwrite,
  input  logic                      id_memtoreg,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src,
  input  logic                      flush,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_cnt
);

  tag_t [FWD_DEPTH:0] tags;
  tag_t               tag_in;
  logic               load;
  logic               src_hit;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               unused_tag_bits;

  always_comb begin
    tag_in          = '0;
    tag_in.valid    = id_valid;
    tag_in.dst      = TAG_AW_MAX'(id_dst);
    tag_in.memtoreg = id_memtoreg;
`ifdef FWD_ZERO_REG_EN
    tag_in.regwrite = id_regwrite && (id_dst != '0);
`else
    tag_in.regwrite = id_regwrite;
`endif
  end

  assign load = id_valid && !stall && !flush;

  fwd_tag_pipe #(
    .DEPTH (FWD_DEPTH + 1)
  ) u_tag_pipe (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (load),
    .tag_i  (tag_in),
    .tags_o (tags)
  );

  // Scan oldest to youngest so the youngest matching stage overwrites.
  always_comb begin
    fwd_sel = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      for (int unsigned k = FWD_DEPTH; k > 0; k--) begin
        if (tags[k].valid && tags[k].regwrite &&
            tags[k].dst == TAG_AW_MAX'(ex_src[i*REG_AW +: REG_AW])) begin
          fwd_sel[i*SELW +: SELW] = SELW'(k);
        end
      end
    end
  end

  always_comb begin
    src_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (tags[0].dst == TAG_AW_MAX'(id_src[i*REG_AW +: REG_AW])) src_hit = 1'b1;
    end
  end

  assign stall = !flush && tags[0].valid && tags[0].regwrite && tags[0].memtoreg && src_hit;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt       = stall_cnt_q;
  assign unused_tag_bits = ^tags;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: default build plus a FWD_DEPTH=1 / CNT_W=2 instance on shared inputs.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst, id_valid, id_regwrite, id_memtoreg, flush;
  logic [2:0] id_dst;
  logic [5:0] id_src, ex_src;
  logic [3:0] fwd_sel;
  logic [1:0] fwd_sel2;
  logic       stall, stall2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .id_src(id_src),
    .ex_src(ex_src), .flush(flush), .fwd_sel(fwd_sel), .stall(stall),
    .stall_cnt(stall_cnt)
  );

  fwd_hazard_unit #(.REG_AW(3), .NUM_SRC(2), .FWD_DEPTH(1), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .id_src(id_src),
    .ex_src(ex_src), .flush(flush), .fwd_sel(fwd_sel2), .stall(stall2),
    .stall_cnt(stall_cnt2)
  );

  // Reference model: history of what entered EX, index = cycles since entry.
  bit         h_v  [0:7];
  logic [2:0] h_d  [0:7];
  bit         h_rw [0:7];
  bit         h_mr [0:7];
  int         m_cnt, m_cnt2;

  function automatic bit live_writer(int k);
    bit w;
    w = h_v[k] && h_rw[k];
`ifdef FWD_ZERO_REG_EN
    if (h_d[k] == 3'd0) w = 1'b0;
`endif
    return w;
  endfunction

  function automatic int exp_fwd(logic [2:0] src, int depth);
    for (int k = 1; k <= depth; k++)
      if (live_writer(k) && h_d[k] == src) return k;
    return 0;
  endfunction

  function automatic bit exp_stall();
    if (flush) return 1'b0;
    if (!(live_writer(0) && h_mr[0])) return 1'b0;
    return (id_src[2:0] == h_d[0]) || (id_src[5:3] == h_d[0]);
  endfunction

  task automatic tick();
    bit s;
    s = exp_stall();
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 8; k++) h_v[k] = 1'b0;
      m_cnt = 0;
      m_cnt2 = 0;
    end else begin
      if (s) begin
        m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
      for (int k = 7; k > 0; k--) begin
        h_v[k] = h_v[k-1]; h_d[k] = h_d[k-1]; h_rw[k] = h_rw[k-1]; h_mr[k] = h_mr[k-1];
      end
      h_v[0] = id_valid && !s && !flush;
      h_d[0] = id_dst; h_rw[0] = id_regwrite; h_mr[0] = id_memtoreg;
    end
    #1;
  endtask

  task automatic set_id(bit v, logic [2:0] d, bit rw, bit mr, logic [2:0] s0, logic [2:0] s1);
    id_valid = v; id_dst = d; id_regwrite = rw; id_memtoreg = mr; id_src = {s1, s0};
  endtask

  task automatic drain();
    set_id(0, 3'd0, 0, 0, 3'd0, 3'd0);
    flush = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; ex_src = 6'd0;
    set_id(0, 3'd0, 0, 0, 3'd0, 3'd0);
    for (int k = 0; k < 8; k++) h_v[k] = 1'b0;
    m_cnt = 0; m_cnt2 = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b want=0", stall); end
    n_cmp++; if (fwd_sel !== 4'd0) begin n_bad++; $display("FAIL reset_fwd got=%0d want=0", fwd_sel); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d want=0", stall_cnt); end
    n_cmp++; if (stall_cnt2 !== 2'd0) begin n_bad++; $display("FAIL reset_cnt2 got=%0d want=0", stall_cnt2); end
  endtask

  task automatic test_fwd_depth();
    drain();
    set_id(1, 3'd3, 1, 0, 3'd0, 3'd0); tick();
    set_id(1, 3'd4, 1, 0, 3'd1, 3'd1); tick();
    set_id(0, 3'd0, 0, 0, 3'd0, 3'd0);
    ex_src = {3'd6, 3'd3};
    #1;
    n_cmp++; if (fwd_sel[1:0] !== 2'd1) begin n_bad++; $display("FAIL exmem_sel0 got=%0d want=1", fwd_sel[1:0]); end
    n_cmp++; if (fwd_sel[3:2] !== 2'd0) begin n_bad++; $display("FAIL exmem_sel1 got=%0d want=0", fwd_sel[3:2]); end
    n_cmp++; if (fwd_sel2[0] !== 1'b1) begin n_bad++; $display("FAIL exmem_d1_sel0 got=%0d want=1", fwd_sel2[0]); end
    tick();
    #1;
    n_cmp++; if (fwd_sel[1:0] !== 2'd2) begin n_bad++; $display("FAIL memwb_sel0 got=%0d want=2", fwd_sel[1:0]); end
    n_cmp++; if (fwd_sel2[0] !== 1'b0) begin n_bad++; $display("FAIL memwb_d1_sel0 got=%0d want=0", fwd_sel2[0]); end
  endtask

  task automatic test_two_writers();
    drain();
    set_id(1, 3'd5, 1, 0, 3'd0, 3'd0); tick();
    set_id(1, 3'd5, 1, 0, 3'd0, 3'd0); tick();
    set_id(0, 3'd0, 0, 0, 3'd0, 3'd0); tick();
    ex_src = {3'd5, 3'd5};
    #1;
    n_cmp++; if (fwd_sel !== 4'b0101) begin n_bad++; $display("FAIL two_writers got=%b want=0101", fwd_sel); end
  endtask

  task automatic test_load_use();
    int c0;
    drain();
    c0 = m_cnt;
    set_id(1, 3'd2, 1, 1, 3'd0, 3'd0); tick();
    set_id(1, 3'd6, 1, 0, 3'd0, 3'd2);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall got=%b want=1", stall); end
    n_cmp++; if (stall2 !== 1'b1) begin n_bad++; $display("FAIL lu_stall_d1 got=%b want=1", stall2); end
    tick();
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_one_cycle got=%b want=0", stall); end
    n_cmp++; if (int'(stall_cnt) !== c0 + 1) begin n_bad++; $display("FAIL lu_cnt got=%0d want=%0d", stall_cnt, c0 + 1); end
    tick();
    set_id(0, 3'd0, 0, 0, 3'd0, 3'd0);
    ex_src = {3'd2, 3'd7};
    #1;
    n_cmp++; if (fwd_sel[3:2] !== 2'd2) begin n_bad++; $display("FAIL lu_fwd_sel1 got=%0d want=2", fwd_sel[3:2]); end
    n_cmp++; if (fwd_sel2[1] !== 1'b0) begin n_bad++; $display("FAIL lu_d1_sel1 got=%0d want=0", fwd_sel2[1]); end
  endtask

  task automatic test_flush_stall();
    int c0;
    drain();
    c0 = m_cnt;
    set_id(1, 3'd2, 1, 1, 3'd0, 3'd0); tick();
    set_id(1, 3'd7, 1, 0, 3'd2, 3'd0);
    flush = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall got=%b want=0", stall); end
    tick();
    flush = 1'b0;
    set_id(0, 3'd0, 0, 0, 3'd0, 3'd0);
    #1;
    n_cmp++; if (int'(stall_cnt) !== c0) begin n_bad++; $display("FAIL flush_cnt got=%0d want=%0d", stall_cnt, c0); end
    tick();
    ex_src = {3'd2, 3'd7};
    #1;
    n_cmp++; if (fwd_sel !== 4'b1000) begin n_bad++; $display("FAIL flush_bubble got=%b want=1000", fwd_sel); end
  endtask

  task automatic test_reset_mid_stall();
    drain();
    set_id(1, 3'd2, 1, 1, 3'd0, 3'd0); tick();
    set_id(1, 3'd6, 1, 0, 3'd2, 3'd0);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rms_pre got=%b want=1", stall); end
    rst = 1'b1; tick(); rst = 1'b0;
    ex_src = {3'd2, 3'd7};
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rms_stall got=%b want=0", stall); end
    n_cmp++; if (fwd_sel !== 4'd0) begin n_bad++; $display("FAIL rms_fwd got=%b want=0", fwd_sel); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL rms_cnt got=%0d want=0", stall_cnt); end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 5; n++) begin
      set_id(1, 3'd2, 1, 1, 3'd0, 3'd0); tick();
      set_id(1, 3'd6, 1, 0, 3'd0, 3'd2); tick();
      tick();
    end
    set_id(0, 3'd0, 0, 0, 3'd0, 3'd0);
    #1;
    n_cmp++; if (stall_cnt !== 16'd5) begin n_bad++; $display("FAIL sat_cnt16 got=%0d want=5", stall_cnt); end
    n_cmp++; if (stall_cnt2 !== 2'd3) begin n_bad++; $display("FAIL sat_cnt2 got=%0d want=3", stall_cnt2); end
  endtask

  task automatic test_zero_reg();
    logic [1:0] want;
`ifdef FWD_ZERO_REG_EN
    want = 2'd0;
`else
    want = 2'd1;
`endif
    drain();
    set_id(1, 3'd0, 1, 0, 3'd1, 3'd1); tick();
    set_id(1, 3'd4, 1, 0, 3'd1, 3'd1); tick();
    set_id(0, 3'd0, 0, 0, 3'd0, 3'd0);
    ex_src = {3'd4, 3'd0};
    #1;
    n_cmp++; if (fwd_sel[1:0] !== want) begin n_bad++; $display("FAIL zero_reg got=%0d want=%0d", fwd_sel[1:0], want); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 39) == 0);
      flush = ($urandom_range(0, 7) == 0);
      set_id($urandom_range(0, 3) != 0, 3'($urandom), $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, 3'($urandom), 3'($urandom));
      ex_src = 6'($urandom);
      #1;
      n_cmp++; if (stall !== exp_stall()) begin n_bad++; $display("FAIL rnd_stall n=%0d got=%b want=%b", n, stall, exp_stall()); end
      n_cmp++; if (stall2 !== exp_stall()) begin n_bad++; $display("FAIL rnd_stall_d1 n=%0d got=%b want=%b", n, stall2, exp_stall()); end
      n_cmp++; if (int'(fwd_sel[1:0]) !== exp_fwd(ex_src[2:0], 2)) begin n_bad++; $display("FAIL rnd_sel0 n=%0d got=%0d want=%0d", n, fwd_sel[1:0], exp_fwd(ex_src[2:0], 2)); end
      n_cmp++; if (int'(fwd_sel[3:2]) !== exp_fwd(ex_src[5:3], 2)) begin n_bad++; $display("FAIL rnd_sel1 n=%0d got=%0d want=%0d", n, fwd_sel[3:2], exp_fwd(ex_src[5:3], 2)); end
      n_cmp++; if (int'(fwd_sel2) !== exp_fwd(ex_src[5:3], 1) * 2 + exp_fwd(ex_src[2:0], 1)) begin n_bad++; $display("FAIL rnd_sel_d1 n=%0d got=%b", n, fwd_sel2); end
      n_cmp++; if (int'(stall_cnt) !== m_cnt) begin n_bad++; $display("FAIL rnd_cnt n=%0d got=%0d want=%0d", n, stall_cnt, m_cnt); end
      n_cmp++; if (int'(stall_cnt2) !== m_cnt2) begin n_bad++; $display("FAIL rnd_cnt2 n=%0d got=%0d want=%0d", n, stall_cnt2, m_cnt2); end
      tick();
    end
    rst = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fwd_depth();
    test_two_writers();
    test_load_use();
    test_flush_stall();
    test_reset_mid_stall();
    test_saturation();
    test_zero_reg();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
